// File: rtl/integ_burst.sv
// Burst-parallel integrator: rebuilds sample lanes from difference lanes,
// first-order (i_switch=1) or stride-2 over interleaved even/odd lanes (i_switch=0).
module integ_burst #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int DATA_NUM     = 1024,
  parameter int BURST_LEN    = 8,
  parameter int ACC_WIDTH    = 28
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         i_switch,
  input  logic [BURST_LEN-1:0][SAMPLE_WIDTH/2-1:0]     i_d_data,
  input  logic                                         i_d_valid,
  input  logic                                         i_d_last,
  output logic [BURST_LEN-1:0][SAMPLE_WIDTH/2-1:0]     o_y,
  output logic                                         o_y_valid,
  output logic                                         o_y_last
);

  localparam int LW     = SAMPLE_WIDTH / 2;
  localparam int NBEATS = DATA_NUM / BURST_LEN;
  localparam int CW     = $clog2(NBEATS) + 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (LW - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic [CW-1:0] cnt_q, cnt_d;

  logic [BURST_LEN-1:0][LW-1:0] s1_data_q;
  logic s1_valid_q, s1_last_q, s1_mode_q, s1_start_q;

  logic signed [ACC_WIDTH-1:0] ext [BURST_LEN];
  logic signed [ACC_WIDTH-1:0] p_d [BURST_LEN];
  logic signed [ACC_WIDTH-1:0] run_all, run_even, run_odd;

  logic signed [ACC_WIDTH-1:0] s2_p_q [BURST_LEN];
  logic s2_valid_q, s2_last_q, s2_mode_q, s2_start_q;

  logic signed [ACC_WIDTH-1:0] b0, b1, c0_q, c1_q;
  logic signed [ACC_WIDTH-1:0] y_d [BURST_LEN];
  logic signed [ACC_WIDTH-1:0] s3_y_q [BURST_LEN];
  logic s3_valid_q, s3_last_q;

  logic [BURST_LEN-1:0][LW-1:0] sat_d;

  // Frame ends on an explicit last or after DATA_NUM samples, whichever is first
  always_comb begin
    cnt_d = cnt_q;
    if (i_d_valid) begin
      if (i_d_last || (cnt_q == CW'(NBEATS - 1))) cnt_d = '0;
      else                                         cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_start_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      s1_data_q  <= i_d_data;
      s1_valid_q <= i_d_valid;
      s1_last_q  <= i_d_last;
      s1_mode_q  <= i_switch;
      s1_start_q <= (cnt_q == '0);
    end
  end

  generate
    for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_ext
      assign ext[gi] = ACC_WIDTH'(signed'(s1_data_q[gi]));
    end
  endgenerate

  // Three running sums in one sweep; each lane picks full or same-parity prefix
  always_comb begin
    run_all  = '0;
    run_even = '0;
    run_odd  = '0;
    for (int k = 0; k < BURST_LEN; k++) begin
      run_all = run_all + ext[k];
      if ((k % 2) == 0) begin
        run_even = run_even + ext[k];
        p_d[k]   = s1_mode_q ? run_all : run_even;
      end else begin
        run_odd = run_odd + ext[k];
        p_d[k]  = s1_mode_q ? run_all : run_odd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < BURST_LEN; k++) s2_p_q[k] <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_mode_q  <= 1'b0;
      s2_start_q <= 1'b0;
    end else begin
      for (int k = 0; k < BURST_LEN; k++) s2_p_q[k] <= p_d[k];
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_mode_q  <= s1_mode_q;
      s2_start_q <= s1_start_q;
    end
  end

  assign b0 = s2_start_q ? '0 : c0_q;
  assign b1 = s2_start_q ? '0 : c1_q;

  generate
    for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_carry
      if ((gi % 2) == 1) begin : g_odd
        assign y_d[gi] = b1 + s2_p_q[gi];
      end else begin : g_even
        assign y_d[gi] = (s2_mode_q ? b1 : b0) + s2_p_q[gi];
      end
    end
  endgenerate

  // Carries keep full accumulator precision and wrap rather than clip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < BURST_LEN; k++) s3_y_q[k] <= '0;
      s3_valid_q <= 1'b0;
      s3_last_q  <= 1'b0;
      c0_q       <= '0;
      c1_q       <= '0;
    end else begin
      for (int k = 0; k < BURST_LEN; k++) s3_y_q[k] <= y_d[k];
      s3_valid_q <= s2_valid_q;
      s3_last_q  <= s2_last_q;
      if (s2_valid_q) begin
        c0_q <= y_d[BURST_LEN-2];
        c1_q <= y_d[BURST_LEN-1];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < BURST_LEN; gi++) begin : g_sat
      assign sat_d[gi] = (s3_y_q[gi] > SAT_MAX) ? SAT_MAX[LW-1:0] :
                         (s3_y_q[gi] < SAT_MIN) ? SAT_MIN[LW-1:0] :
                                                  s3_y_q[gi][LW-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_y       <= '0;
      o_y_valid <= 1'b0;
      o_y_last  <= 1'b0;
    end else begin
      if (s3_valid_q) o_y <= sat_d;
      o_y_valid <= s3_valid_q;
      o_y_last  <= s3_valid_q & s3_last_q;
    end
  end

endmodule

// File: tb/tb_integ_burst.sv
// Directed bench for integ_burst: fixed vectors with hand-computed expected beats,
// checked by immediate assertions in one linear stimulus sequence.
module tb_integ_burst;

  typedef logic [7:0][15:0] beat_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  i_switch;
  beat_t i_d_data;
  logic  i_d_valid;
  logic  i_d_last;
  beat_t o_y;
  logic  o_y_valid;
  logic  o_y_last;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  beat_t out_data_q[$];
  bit    out_last_q[$];
  int    out_cyc_q[$];
  int    in_cyc_q[$];

  integ_burst #(
    .SAMPLE_WIDTH(32), .DATA_NUM(1024), .BURST_LEN(8), .ACC_WIDTH(28)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_switch(i_switch),
    .i_d_data(i_d_data), .i_d_valid(i_d_valid), .i_d_last(i_d_last),
    .o_y(o_y), .o_y_valid(o_y_valid), .o_y_last(o_y_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && o_y_valid) begin
      out_data_q.push_back(o_y);
      out_last_q.push_back(o_y_last);
      out_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  function automatic beat_t ramp(input int s);
    beat_t r;
    for (int k = 0; k < 8; k++) r[k] = 16'(s + k);
    return r;
  endfunction

  function automatic beat_t fill(input int v);
    beat_t r;
    for (int k = 0; k < 8; k++) r[k] = 16'(v);
    return r;
  endfunction

  task automatic send(input beat_t d, input bit mode, input bit last);
    @(posedge clk); #1;
    i_d_data  = d;
    i_switch  = mode;
    i_d_valid = 1'b1;
    i_d_last  = last;
    in_cyc_q.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_d_valid = 1'b0;
      i_d_last  = 1'b0;
    end
  endtask

  task automatic flush();
    out_data_q.delete();
    out_last_q.delete();
    out_cyc_q.delete();
    in_cyc_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    i_d_valid = 1'b0;
    i_d_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    flush();
  endtask

  task automatic wait_out(input int n);
    int budget = 200;
    while (out_data_q.size() < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
  endtask

  task automatic check_out(input string tag, input beat_t exp, input bit exp_last);
    beat_t got;
    bit    gl;
    int    lat;
    if (out_data_q.size() == 0 || in_cyc_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: no output beat seen, required %h", tag, exp);
    end else begin
      got = out_data_q.pop_front();
      gl  = out_last_q.pop_front();
      lat = out_cyc_q.pop_front() - in_cyc_q.pop_front();
      $display("beat %s: y0=%0d y7=%0d last=%0b latency=%0d",
               tag, $signed(got[0]), $signed(got[7]), gl, lat);
      checks++;
      assert (got === exp) else begin
        failures++;
        $error("FAIL %s data: got %h required %h", tag, got, exp);
      end
      checks++;
      assert (gl === exp_last) else begin
        failures++;
        $error("FAIL %s last: got %0b required %0b", tag, gl, exp_last);
      end
      checks++;
      assert (lat == 4) else begin
        failures++;
        $error("FAIL %s latency: got %0d required 4", tag, lat);
      end
    end
  endtask

  initial begin
    beat_t m0;
    rst_n     = 1'b0;
    i_switch  = 1'b1;
    i_d_data  = '0;
    i_d_valid = 1'b0;
    i_d_last  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (o_y === '0 && o_y_valid === 1'b0 && o_y_last === 1'b0) else begin
      failures++;
      $error("FAIL reset_state: got y=%h v=%0b l=%0b required all zero", o_y, o_y_valid, o_y_last);
    end
    rst_n = 1'b1;

    // First-order, two back-to-back beats
    send(fill(1), 1'b1, 1'b0);
    send(fill(1), 1'b1, 1'b1);
    idle(1);
    wait_out(2);
    check_out("m1_b1", ramp(1), 1'b0);
    check_out("m1_b2", ramp(9), 1'b1);

    // Stride-2: even lanes d=1, odd lanes d=2
    for (int k = 0; k < 8; k++) m0[k] = ((k % 2) == 0) ? 16'd1 : 16'd2;
    send(m0, 1'b0, 1'b0);
    send(m0, 1'b0, 1'b1);
    idle(1);
    wait_out(2);
    check_out("m0_b1", {16'd8, 16'd4, 16'd6, 16'd3, 16'd4, 16'd2, 16'd2, 16'd1}, 1'b0);
    check_out("m0_b2", {16'd16, 16'd8, 16'd14, 16'd7, 16'd12, 16'd6, 16'd10, 16'd5}, 1'b1);

    // Saturation both ways; carry after beat 2 is -8
    send(fill(32767), 1'b1, 1'b0);
    send(fill(-32768), 1'b1, 1'b0);
    send(fill(-32768), 1'b1, 1'b0);
    send(fill(-32768), 1'b1, 1'b1);
    idle(1);
    wait_out(4);
    check_out("sat_pos", fill(32767), 1'b0);
    check_out("sat_mix", {16'hFFF8, 16'd32760, 16'd32767, 16'd32767,
                          16'd32767, 16'd32767, 16'd32767, 16'd32767}, 1'b0);
    check_out("sat_neg1", fill(-32768), 1'b0);
    check_out("sat_neg2", fill(-32768), 1'b1);

    // Frame wrap on beat count alone
    for (int n = 0; n < 129; n++) send(fill(1), 1'b1, 1'b0);
    idle(1);
    wait_out(129);
    for (int n = 1; n <= 129; n++)
      check_out($sformatf("wrap_b%0d", n), (n <= 128) ? ramp(8 * (n - 1) + 1) : ramp(1), 1'b0);
    do_reset();

    // Early frame end via last on beat 3
    send(fill(1), 1'b1, 1'b0);
    send(fill(1), 1'b1, 1'b0);
    send(fill(1), 1'b1, 1'b1);
    send(fill(1), 1'b1, 1'b0);
    idle(1);
    wait_out(4);
    check_out("last_b1", ramp(1), 1'b0);
    check_out("last_b2", ramp(9), 1'b0);
    check_out("last_b3", ramp(17), 1'b1);
    check_out("last_b4", ramp(1), 1'b0);
    do_reset();

    // Gapped input; output holds during the gap
    send(fill(1), 1'b1, 1'b0);
    idle(5);
    checks++;
    assert (o_y === ramp(1) && o_y_valid === 1'b0) else begin
      failures++;
      $error("FAIL gap_hold: got y=%h v=%0b required %h v=0", o_y, o_y_valid, ramp(1));
    end
    send(fill(1), 1'b1, 1'b1);
    idle(1);
    wait_out(2);
    check_out("gap_b1", ramp(1), 1'b0);
    check_out("gap_b2", ramp(9), 1'b1);
    idle(2);

    // Asynchronous reset with beats in flight
    send(fill(1), 1'b1, 1'b0);
    send(fill(1), 1'b1, 1'b0);
    @(posedge clk); #1;
    rst_n     = 1'b0;
    i_d_valid = 1'b0;
    #1;
    checks++;
    assert (o_y === '0 && o_y_valid === 1'b0 && o_y_last === 1'b0) else begin
      failures++;
      $error("FAIL rst_async: got y=%h v=%0b l=%0b required all zero", o_y, o_y_valid, o_y_last);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    flush();
    idle(6);
    checks++;
    assert (out_data_q.size() == 0) else begin
      failures++;
      $error("FAIL rst_stale: got %0d output beats required 0", out_data_q.size());
    end
    send(fill(1), 1'b1, 1'b1);
    idle(1);
    wait_out(1);
    check_out("rst_b1", ramp(1), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/integ_burst.md
Name: integ_burst

Overview:
- Burst-parallel integrator that reconstructs sample streams from difference streams. It is the inverse of the prep-chain differentiator.
- Each beat carries BURST_LEN signed samples. The block keeps a running sum across beats within a frame of DATA_NUM samples.
- Mode i_switch=1: first-order sum. Mode i_switch=0: stride-2 sum over interleaved even/odd lanes.
- Sits on the reconstruction/verification path, after the differentiator's output.

Parameters:
- SAMPLE_WIDTH, 32, sample container width; lane width is SAMPLE_WIDTH/2.
- DATA_NUM, 1024, samples per frame; must be a multiple of BURST_LEN.
- BURST_LEN, 8, lanes per beat; must be even, ≥2.
- ACC_WIDTH, 28, internal accumulator width in bits, signed, ≥ SAMPLE_WIDTH/2+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_switch  in  1  mode, sampled with each valid beat: 1 = first-order, 0 = stride-2
- i_d_data  in  [SAMPLE_WIDTH/2-1:0] x BURST_LEN  signed difference lanes; lane 0 is the oldest sample
- i_d_valid  in  1  beat valid; no backpressure
- i_d_last  in  1  last beat of frame, qualified by i_d_valid
- o_y  out  [SAMPLE_WIDTH/2-1:0] x BURST_LEN  reconstructed signed samples, saturated
- o_y_valid  out  1  output beat valid
- o_y_last  out  1  output last beat, aligned with o_y_valid

Behaviour:
- Reset: all pipeline registers, carries c0 and c1, the beat counter, o_y (all lanes 0), o_y_valid=0 and o_y_last=0 clear asynchronously. A reset mid-frame discards in-flight beats; the first beat after reset is a frame start.
- Latency: fixed 4 cycles from i_d_valid to o_y_valid. Data, last and mode travel with their beat.
- Stage 1: register data, valid, last, mode, and a frame-start flag (beat counter == 0).
- Stage 2, in-burst prefix sums, sign-extended to ACC_WIDTH:
  - mode 1: p[k] = sum of d[0..k].
  - mode 0: p[k] = sum of d[j] for j ≤ k and j ≡ k (mod 2).
- Stage 3, carry add:
  - Base values: if frame start, b0 = b1 = 0; otherwise b0 = c0 and b1 = c1.
  - mode 1: y[k] = b1 + p[k] for all k.
  - mode 0: y[k] = b0 + p[k] for even k, b1 + p[k] for odd k.
  - On each valid beat only: c0 <= y[BURST_LEN-2], c1 <= y[BURST_LEN-1] at full ACC_WIDTH precision. Carries hold on idle cycles.
- Stage 4: saturate each y[k] to [-2^(SAMPLE_WIDTH/2-1), 2^(SAMPLE_WIDTH/2-1)-1] and register into o_y.
  - o_y updates only on valid beats and holds otherwise.
  - Accumulators are not clipped; they wrap modulo 2^ACC_WIDTH.
- Beat counter, width log2(DATA_NUM/BURST_LEN)+1:
  - Increments on each valid input beat.
  - Returns to 0 after a beat that has i_d_last=1 or counter == DATA_NUM/BURST_LEN-1, whichever comes first.
  - If both happen on the same beat, it restarts once.
- o_y_last = i_d_last delayed with its beat. It is not generated on counter wrap.
- Mode change mid-frame: carries are kept. Mode 1 continues from c1; mode 0 uses c0/c1 as they stand.
- Idle gaps of any length between beats do not change results.

Test Plan:
- Mode 1, frame start, all lanes d=1, two back-to-back beats -> beat 1 o_y=1..8, beat 2 o_y=9..16; o_y_valid asserted 4 cycles after each input beat.
- Mode 0, even lanes d=1, odd lanes d=2, two beats -> beat 1 even lanes 1,2,3,4 and odd lanes 2,4,6,8; beat 2 even lanes 5..8 and odd lanes 10..16.
- Saturation, mode 1: d=32767 on all lanes -> o_y[0]=32767, lanes 1..7 clamp to 32767. Then all lanes d=-32768 for 3 beats -> output reaches -32768 and holds there. Accumulator stays in range with no wrap at ACC_WIDTH=28.
- Frame boundary, DATA_NUM=1024, all lanes d=1, 129 consecutive beats -> beat 128 o_y=1017..1024; beat 129 restarts at 1..8 with no i_d_last. Separately, i_d_last on beat 3 -> beat 4 restarts at 1..8 and o_y_last is high on output beat 3 only.
- Gapped input: same stimulus as the first scenario with 5 idle cycles between beats -> identical o_y values; o_y holds 1..8 during the gap.
- Reset asserted mid-frame after beat 2 and released -> all outputs 0 immediately; the next beat with d=1 gives o_y=1..8 and no stale valid is emitted.
